// File: rtl/fireball_engine_pkg.sv
// Shared types and constants for the fireball game engine.
// Holds the FSM encoding, path geometry, park position and hit radius.
package fireball_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    localparam int NUM_FIRE = 4;
    localparam int PATH_LEN = 140;
    localparam logic [7:0] LAST_IDX = 8'(PATH_LEN - 1);

    localparam logic [6:0] PARK_X = 7'd127;
    localparam logic [5:0] PARK_Y = 6'd0;

    localparam logic signed [7:0] HIT_RADIUS = 8'sd3;

    // Last index of each path segment
    localparam logic [7:0] SEG0_END = 8'd20;
    localparam logic [7:0] SEG1_END = 8'd36;
    localparam logic [7:0] SEG2_END = 8'd60;
    localparam logic [7:0] SEG3_END = 8'd76;
    localparam logic [7:0] SEG4_END = 8'd100;
    localparam logic [7:0] SEG5_END = 8'd116;

    // Horizontal runs: x = i + off (or i - off), fixed y.
    // Vertical runs: fixed x, y = i - off.
    localparam logic [7:0] SEG0_XOFF = 8'd2;
    localparam logic [5:0] SEG0_Y    = 6'd13;
    localparam logic [6:0] SEG1_X    = 7'd23;
    localparam logic [7:0] SEG1_YOFF = 8'd8;
    localparam logic [7:0] SEG2_XOFF = 8'd14;
    localparam logic [5:0] SEG2_Y    = 6'd29;
    localparam logic [6:0] SEG3_X    = 7'd47;
    localparam logic [7:0] SEG3_YOFF = 8'd32;
    localparam logic [7:0] SEG4_XOFF = 8'd30;
    localparam logic [5:0] SEG4_Y    = 6'd45;
    localparam logic [6:0] SEG5_X    = 7'd71;
    localparam logic [7:0] SEG5_YOFF = 8'd56;
    localparam logic [7:0] SEG6_XOFF = 8'd46;
    localparam logic [5:0] SEG6_Y    = 6'd61;

    // True when two coordinates lie within the hit radius.
    // Operands are zero-extended to 8 bits so the signed difference
    // never wraps across the screen edge.
    function automatic logic in_reach(input logic [7:0] a,
                                      input logic [7:0] b);
        logic signed [7:0] d;
        d = a - b;
        return (d >= -HIT_RADIUS) && (d <= HIT_RADIUS);
    endfunction

endpackage

// File: rtl/fireball_engine_path_lut.sv
// fire_path_lut: combinational path index -> (x,y) screen coordinate.
// Ports: idx_i path index 0..139; x_o 7-bit x; y_o 6-bit y.
module fire_path_lut
    import fireball_engine_pkg::*;
(
    input  logic [7:0] idx_i,
    output logic [6:0] x_o,
    output logic [5:0] y_o
);

    logic s0, s1, s2, s3, s4, s5, s6;

    assign s0 = (idx_i <= SEG0_END);
    assign s1 = (idx_i > SEG0_END) && (idx_i <= SEG1_END);
    assign s2 = (idx_i > SEG1_END) && (idx_i <= SEG2_END);
    assign s3 = (idx_i > SEG2_END) && (idx_i <= SEG3_END);
    assign s4 = (idx_i > SEG3_END) && (idx_i <= SEG4_END);
    assign s5 = (idx_i > SEG4_END) && (idx_i <= SEG5_END);
    assign s6 = (idx_i > SEG5_END);

    always_comb begin
        x_o = PARK_X;
        y_o = PARK_Y;
        unique case (1'b1)
            s0: begin
                x_o = 7'(idx_i + SEG0_XOFF);
                y_o = SEG0_Y;
            end
            s1: begin
                x_o = SEG1_X;
                y_o = 6'(idx_i - SEG1_YOFF);
            end
            s2: begin
                x_o = 7'(idx_i - SEG2_XOFF);
                y_o = SEG2_Y;
            end
            s3: begin
                x_o = SEG3_X;
                y_o = 6'(idx_i - SEG3_YOFF);
            end
            s4: begin
                x_o = 7'(idx_i - SEG4_XOFF);
                y_o = SEG4_Y;
            end
            s5: begin
                x_o = SEG5_X;
                y_o = 6'(idx_i - SEG5_YOFF);
            end
            s6: begin
                x_o = 7'(idx_i - SEG6_XOFF);
                y_o = SEG6_Y;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fireball_engine.sv
// Game-state and sprite-motion engine: moves four fireballs along the
// path, detects snowball hits, tracks lives, cooldown and win/lose.
// Ports: clk/rst_n; move_tick pace; start (re)starts a game;
// char_x/char_y snowball centre; fireN_x/fireN_y fireball centres;
// life, cooldown, cd_cnt, win, game_over game status (all registered).
module fireball_engine
    import fireball_engine_pkg::*;
#(
    parameter int SPAWN_GAP = 12,
    parameter int WIN_COUNT = 20,
    parameter int CD_TICKS  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_tick,
    input  logic       start,
    input  logic [6:0] char_x,
    input  logic [5:0] char_y,
    output logic [6:0] fire1_x,
    output logic [5:0] fire1_y,
    output logic [6:0] fire2_x,
    output logic [5:0] fire2_y,
    output logic [6:0] fire3_x,
    output logic [5:0] fire3_y,
    output logic [6:0] fire4_x,
    output logic [5:0] fire4_y,
    output logic [1:0] life,
    output logic       cooldown,
    output logic [2:0] cd_cnt,
    output logic       win,
    output logic       game_over
);

    localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_GAP - 1);
    localparam logic [7:0] WIN_LAST   = 8'(WIN_COUNT);
    localparam logic [2:0] CD_LOAD    = 3'(CD_TICKS);

    state_e state_q, state_d;

    logic [NUM_FIRE-1:0] act_q, act_d;
    logic [7:0] idx_q [NUM_FIRE];
    logic [7:0] idx_d [NUM_FIRE];
    logic [6:0] fx_q  [NUM_FIRE];
    logic [6:0] fx_d  [NUM_FIRE];
    logic [5:0] fy_q  [NUM_FIRE];
    logic [5:0] fy_d  [NUM_FIRE];
    logic [6:0] lut_x [NUM_FIRE];
    logic [5:0] lut_y [NUM_FIRE];

    logic [7:0] spawn_q, spawn_d;
    logic [7:0] esc_q, esc_d;
    logic [1:0] life_q, life_d;
    logic       cool_q, cool_d;
    logic [2:0] cd_q, cd_d;
    logic       win_q, over_q;

    logic [NUM_FIRE-1:0] near;
    logic                hit;
    logic                free_ok;
    logic [1:0]          free_idx;

    // Positions are looked up from next-state indices so the
    // registered outputs change together with the slot state.
    for (genvar g = 0; g < NUM_FIRE; g++) begin : g_lut
        fire_path_lut u_lut (
            .idx_i (idx_d[g]),
            .x_o   (lut_x[g]),
            .y_o   (lut_y[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_FIRE; i++) begin
            fx_d[i] = act_d[i] ? lut_x[i] : PARK_X;
            fy_d[i] = act_d[i] ? lut_y[i] : PARK_Y;
        end
    end

    // Overlap is judged on registered (pre-move) positions
    always_comb begin
        for (int i = 0; i < NUM_FIRE; i++) begin
            near[i] = act_q[i]
                && in_reach({1'b0, char_x}, {1'b0, fx_q[i]})
                && in_reach({2'b0, char_y}, {2'b0, fy_q[i]});
        end
        hit = (state_q == ST_PLAY) && !cool_q && (|near);
    end

    // Lowest-numbered slot that was free before this tick
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        for (int i = NUM_FIRE - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_ok  = 1'b1;
                free_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        for (int i = 0; i < NUM_FIRE; i++) begin
            idx_d[i] = idx_q[i];
        end
        spawn_d = spawn_q;
        esc_d   = esc_q;
        life_d  = life_q;
        cool_d  = cool_q;
        cd_d    = cd_q;

        if (start) begin
            state_d = ST_PLAY;
            act_d   = '0;
            for (int i = 0; i < NUM_FIRE; i++) begin
                idx_d[i] = '0;
            end
            spawn_d = '0;
            esc_d   = '0;
            life_d  = 2'd3;
            cool_d  = 1'b0;
            cd_d    = '0;
        end else if (state_q == ST_PLAY) begin
            if (hit) begin
                life_d = life_q - 2'd1;
                cool_d = 1'b1;
                cd_d   = CD_LOAD;
            end
            if (move_tick) begin
                // A fresh hit reloads the counter instead of counting
                if (!hit && cool_q) begin
                    cd_d = cd_q - 3'd1;
                    if (cd_q == 3'd1) begin
                        cool_d = 1'b0;
                    end
                end
                for (int i = 0; i < NUM_FIRE; i++) begin
                    if (act_q[i]) begin
                        if (idx_q[i] == LAST_IDX) begin
                            act_d[i] = 1'b0;
                            esc_d    = esc_d + 8'd1;
                        end else begin
                            idx_d[i] = idx_q[i] + 8'd1;
                        end
                    end
                end
                // Holds at SPAWN_LAST while every slot is busy
                if (spawn_q == SPAWN_LAST) begin
                    if (free_ok) begin
                        act_d[free_idx] = 1'b1;
                        idx_d[free_idx] = '0;
                        spawn_d         = '0;
                    end
                end else begin
                    spawn_d = spawn_q + 8'd1;
                end
            end
            // Losing the last life beats a simultaneous final escape
            if (life_d == 2'd0) begin
                state_d = ST_OVER;
            end else if (esc_d >= WIN_LAST) begin
                state_d = ST_WIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            for (int i = 0; i < NUM_FIRE; i++) begin
                idx_q[i] <= '0;
                fx_q[i]  <= PARK_X;
                fy_q[i]  <= PARK_Y;
            end
            spawn_q <= '0;
            esc_q   <= '0;
            life_q  <= 2'd3;
            cool_q  <= 1'b0;
            cd_q    <= '0;
            win_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            for (int i = 0; i < NUM_FIRE; i++) begin
                idx_q[i] <= idx_d[i];
                fx_q[i]  <= fx_d[i];
                fy_q[i]  <= fy_d[i];
            end
            spawn_q <= spawn_d;
            esc_q   <= esc_d;
            life_q  <= life_d;
            cool_q  <= cool_d;
            cd_q    <= cd_d;
            win_q   <= (state_d == ST_WIN);
            over_q  <= (state_d == ST_OVER);
        end
    end

    assign fire1_x   = fx_q[0];
    assign fire1_y   = fy_q[0];
    assign fire2_x   = fx_q[1];
    assign fire2_y   = fy_q[1];
    assign fire3_x   = fx_q[2];
    assign fire3_y   = fy_q[2];
    assign fire4_x   = fx_q[3];
    assign fire4_y   = fy_q[3];
    assign life      = life_q;
    assign cooldown  = cool_q;
    assign cd_cnt    = cd_q;
    assign win       = win_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_fireball_engine.sv
// Directed bench for fireball_engine: default build (A) plus a
// short-spawn, two-escape build (B) for overlap and win scenarios.
module tb_fireball_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       mv_a = 1'b0, st_a = 1'b0;
    logic [6:0] cx_a = 7'd0;
    logic [5:0] cy_a = 6'd63;
    logic [6:0] a_f1x, a_f2x, a_f3x, a_f4x;
    logic [5:0] a_f1y, a_f2y, a_f3y, a_f4y;
    logic [1:0] a_life;
    logic       a_cool, a_win, a_over;
    logic [2:0] a_cd;

    logic       mv_b = 1'b0, st_b = 1'b0;
    logic [6:0] cx_b = 7'd0;
    logic [5:0] cy_b = 6'd63;
    logic [6:0] b_f1x, b_f2x, b_f3x, b_f4x;
    logic [5:0] b_f1y, b_f2y, b_f3y, b_f4y;
    logic [1:0] b_life;
    logic       b_cool, b_win, b_over;
    logic [2:0] b_cd;

    int n_cmp = 0;
    int n_bad = 0;

    fireball_engine dut_a (
        .clk(clk), .rst_n(rst_n), .move_tick(mv_a), .start(st_a),
        .char_x(cx_a), .char_y(cy_a),
        .fire1_x(a_f1x), .fire1_y(a_f1y), .fire2_x(a_f2x), .fire2_y(a_f2y),
        .fire3_x(a_f3x), .fire3_y(a_f3y), .fire4_x(a_f4x), .fire4_y(a_f4y),
        .life(a_life), .cooldown(a_cool), .cd_cnt(a_cd),
        .win(a_win), .game_over(a_over)
    );

    fireball_engine #(.SPAWN_GAP(2), .WIN_COUNT(2), .CD_TICKS(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .move_tick(mv_b), .start(st_b),
        .char_x(cx_b), .char_y(cy_b),
        .fire1_x(b_f1x), .fire1_y(b_f1y), .fire2_x(b_f2x), .fire2_y(b_f2y),
        .fire3_x(b_f3x), .fire3_y(b_f3y), .fire4_x(b_f4x), .fire4_y(b_f4y),
        .life(b_life), .cooldown(b_cool), .cd_cnt(b_cd),
        .win(b_win), .game_over(b_over)
    );

    task automatic tick_a(input int n);
        repeat (n) begin
            @(negedge clk); mv_a = 1'b1;
            @(negedge clk); mv_a = 1'b0;
        end
    endtask

    task automatic tick_b(input int n);
        repeat (n) begin
            @(negedge clk); mv_b = 1'b1;
            @(negedge clk); mv_b = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL reset_f1: got (%0d,%0d) want (127,0)", a_f1x, a_f1y);
        end
        n_cmp++;
        if ({a_f4x, a_f4y} !== {7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL reset_f4: got (%0d,%0d) want (127,0)", a_f4x, a_f4y);
        end
        n_cmp++;
        if (a_life !== 2'd3) begin
            n_bad++;
            $display("FAIL reset_life: got %0d want 3", a_life);
        end
        n_cmp++;
        if ({a_cool, a_cd, a_win, a_over} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got cool=%0d cd=%0d win=%0d over=%0d want 0",
                     a_cool, a_cd, a_win, a_over);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_spawn();
        @(negedge clk); st_a = 1'b1;
        @(negedge clk); st_a = 1'b0;
        tick_a(11);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL spawn_early: got (%0d,%0d) want (127,0)", a_f1x, a_f1y);
        end
        tick_a(1);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd2, 6'd13}) begin
            n_bad++;
            $display("FAIL spawn_f1: got (%0d,%0d) want (2,13)", a_f1x, a_f1y);
        end
        n_cmp++;
        if ({a_f2x, a_f2y, a_f3x, a_f3y, a_f4x, a_f4y} !==
            {7'd127, 6'd0, 7'd127, 6'd0, 7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL spawn_others: got f2=(%0d,%0d) f3=(%0d,%0d) f4=(%0d,%0d) want parked",
                     a_f2x, a_f2y, a_f3x, a_f3y, a_f4x, a_f4y);
        end
    endtask

    task automatic test_path();
        tick_a(21);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd23, 6'd13}) begin
            n_bad++;
            $display("FAIL path_idx21: got (%0d,%0d) want (23,13)", a_f1x, a_f1y);
        end
        tick_a(118);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd93, 6'd61}) begin
            n_bad++;
            $display("FAIL path_idx139: got (%0d,%0d) want (93,61)", a_f1x, a_f1y);
        end
        tick_a(1);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL path_escape: got (%0d,%0d) want (127,0)", a_f1x, a_f1y);
        end
        n_cmp++;
        if ({a_f2x, a_f2y} !== {7'd82, 6'd61}) begin
            n_bad++;
            $display("FAIL path_f2: got (%0d,%0d) want (82,61)", a_f2x, a_f2y);
        end
        n_cmp++;
        if (a_life !== 2'd3 || a_win !== 1'b0) begin
            n_bad++;
            $display("FAIL path_status: got life=%0d win=%0d want 3,0", a_life, a_win);
        end
    endtask

    task automatic test_hit_cooldown();
        @(negedge clk); st_a = 1'b1;
        @(negedge clk); st_a = 1'b0;
        tick_a(12);
        @(negedge clk); cx_a = 7'd5; cy_a = 6'd16;
        @(negedge clk);
        n_cmp++;
        if ({a_life, a_cool, a_cd} !== {2'd2, 1'b1, 3'd7}) begin
            n_bad++;
            $display("FAIL hit_first: got life=%0d cool=%0d cd=%0d want 2,1,7",
                     a_life, a_cool, a_cd);
        end
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            mv_a = 1'b1;
            cx_a = 7'(2 + j);
            cy_a = 6'd14;
            @(negedge clk);
            mv_a = 1'b0;
            if (j == 7) begin
                cx_a = 7'd0;
                cy_a = 6'd63;
            end
            n_cmp++;
            if ({a_life, a_cool, a_cd} !== {2'd2, (j < 7), 3'(7 - j)}) begin
                n_bad++;
                $display("FAIL cooldown_tick%0d: got life=%0d cool=%0d cd=%0d want 2,%0d,%0d",
                         j, a_life, a_cool, a_cd, (j < 7), 7 - j);
            end
        end
    endtask

    task automatic test_game_over();
        @(negedge clk); cx_a = 7'd9; cy_a = 6'd13;
        @(negedge clk); cx_a = 7'd0; cy_a = 6'd63;
        n_cmp++;
        if ({a_life, a_cd} !== {2'd1, 3'd7}) begin
            n_bad++;
            $display("FAIL hit_second: got life=%0d cd=%0d want 1,7", a_life, a_cd);
        end
        tick_a(7);
        n_cmp++;
        if ({a_life, a_cool} !== {2'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL cooldown_end: got life=%0d cool=%0d want 1,0", a_life, a_cool);
        end
        @(negedge clk); cx_a = 7'd16; cy_a = 6'd13; mv_a = 1'b1;
        @(negedge clk); cx_a = 7'd0; cy_a = 6'd63; mv_a = 1'b0;
        n_cmp++;
        if ({a_life, a_cool, a_cd, a_over, a_win} !== {2'd0, 1'b1, 3'd7, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL hit_with_tick: got life=%0d cool=%0d cd=%0d over=%0d win=%0d want 0,1,7,1,0",
                     a_life, a_cool, a_cd, a_over, a_win);
        end
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd17, 6'd13}) begin
            n_bad++;
            $display("FAIL over_move: got (%0d,%0d) want (17,13)", a_f1x, a_f1y);
        end
        tick_a(3);
        n_cmp++;
        if ({a_f1x, a_f1y, a_cd} !== {7'd17, 6'd13, 3'd7}) begin
            n_bad++;
            $display("FAIL over_frozen: got (%0d,%0d) cd=%0d want (17,13) cd=7",
                     a_f1x, a_f1y, a_cd);
        end
    endtask

    task automatic test_start_tick();
        @(negedge clk); st_a = 1'b1; mv_a = 1'b1;
        @(negedge clk); st_a = 1'b0; mv_a = 1'b0;
        n_cmp++;
        if ({a_life, a_over, a_cool, a_cd} !== {2'd3, 1'b0, 1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL restart: got life=%0d over=%0d cool=%0d cd=%0d want 3,0,0,0",
                     a_life, a_over, a_cool, a_cd);
        end
        tick_a(11);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL start_no_motion: got (%0d,%0d) want (127,0)", a_f1x, a_f1y);
        end
        tick_a(1);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd2, 6'd13}) begin
            n_bad++;
            $display("FAIL restart_spawn: got (%0d,%0d) want (2,13)", a_f1x, a_f1y);
        end
    endtask

    task automatic test_double_hit();
        @(negedge clk); st_b = 1'b1;
        @(negedge clk); st_b = 1'b0;
        tick_b(4);
        n_cmp++;
        if ({b_f1x, b_f1y, b_f2x, b_f2y} !== {7'd4, 6'd13, 7'd2, 6'd13}) begin
            n_bad++;
            $display("FAIL dbl_pos: got f1=(%0d,%0d) f2=(%0d,%0d) want (4,13),(2,13)",
                     b_f1x, b_f1y, b_f2x, b_f2y);
        end
        @(negedge clk); cx_b = 7'd3; cy_b = 6'd13;
        @(negedge clk); cx_b = 7'd0; cy_b = 6'd63;
        n_cmp++;
        if ({b_life, b_cool} !== {2'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL dbl_hit: got life=%0d cool=%0d want 2,1", b_life, b_cool);
        end
    endtask

    task automatic test_final_escape_hit();
        tick_b(7);
        n_cmp++;
        if (b_cool !== 1'b0) begin
            n_bad++;
            $display("FAIL b_cool_end: got %0d want 0", b_cool);
        end
        @(negedge clk); cx_b = 7'd11; cy_b = 6'd13;
        @(negedge clk); cx_b = 7'd0; cy_b = 6'd63;
        n_cmp++;
        if (b_life !== 2'd1) begin
            n_bad++;
            $display("FAIL b_hit2: got life=%0d want 1", b_life);
        end
        tick_b(132);
        n_cmp++;
        if ({b_f2x, b_f2y, b_win, b_over} !== {7'd93, 6'd61, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL b_pre_final: got f2=(%0d,%0d) win=%0d over=%0d want (93,61),0,0",
                     b_f2x, b_f2y, b_win, b_over);
        end
        @(negedge clk); mv_b = 1'b1; cx_b = 7'd93; cy_b = 6'd61;
        @(negedge clk); mv_b = 1'b0; cx_b = 7'd0; cy_b = 6'd63;
        n_cmp++;
        if ({b_life, b_over, b_win} !== {2'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL hit_vs_win: got life=%0d over=%0d win=%0d want 0,1,0",
                     b_life, b_over, b_win);
        end
    endtask

    task automatic test_win();
        @(negedge clk); st_b = 1'b1;
        @(negedge clk); st_b = 1'b0;
        tick_b(142);
        n_cmp++;
        if ({b_f1x, b_f1y, b_win} !== {7'd127, 6'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL win_first_escape: got f1=(%0d,%0d) win=%0d want (127,0),0",
                     b_f1x, b_f1y, b_win);
        end
        tick_b(1);
        n_cmp++;
        if (b_win !== 1'b0) begin
            n_bad++;
            $display("FAIL win_early: got %0d want 0", b_win);
        end
        tick_b(1);
        n_cmp++;
        if ({b_win, b_over, b_life, b_f2x, b_f2y} !== {1'b1, 1'b0, 2'd3, 7'd127, 6'd0}) begin
            n_bad++;
            $display("FAIL win_set: got win=%0d over=%0d life=%0d f2=(%0d,%0d) want 1,0,3,(127,0)",
                     b_win, b_over, b_life, b_f2x, b_f2y);
        end
    endtask

    task automatic test_async_reset();
        tick_a(1);
        n_cmp++;
        if ({a_f1x, a_f1y} !== {7'd3, 6'd13}) begin
            n_bad++;
            $display("FAIL pre_reset: got (%0d,%0d) want (3,13)", a_f1x, a_f1y);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_f1x, a_f1y, a_life, b_win} !== {7'd127, 6'd0, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got f1=(%0d,%0d) life=%0d bwin=%0d want (127,0),3,0",
                     a_f1x, a_f1y, a_life, b_win);
        end
        #10 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_path();
        test_hit_cooldown();
        test_game_over();
        test_start_tick();
        test_double_hit();
        test_final_escape_hit();
        test_win();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
